// File: rtl/rob_multi_if.sv
// Reorder-buffer bus bundle: decoder allocate/check, CDB, branch resolve,
// register-file retire, data-cache store and flush/predictor outputs.
interface rob_if #(
    parameter int TAG_W     = 3,
    parameter int CDB_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int ADDR_W    = 32,
    parameter int BADDR_W   = 10
);
    logic                           alloc_valid;
    logic                           alloc_ready;
    logic [TAG_W-1:0]               alloc_tag;
    logic [2:0]                     alloc_op;
    logic [REG_W-1:0]               alloc_reg;
    logic [ADDR_W-1:0]              alloc_npc;
    logic [BADDR_W-1:0]             alloc_baddr;
    logic [TAG_W-1:0]               chk_tag1, chk_tag2;
    logic [DATA_W-1:0]              chk_val1, chk_val2;
    logic                           chk_rdy1, chk_rdy2;
    logic [CDB_PORTS-1:0]           cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0]     cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0]    cdb_value;
    logic [CDB_PORTS*ADDR_W-1:0]    cdb_addr;
    logic                           bra_valid;
    logic [TAG_W-1:0]               bra_tag;
    logic                           bra_taken;
    logic                           bra_mispred;
    logic                           rf_we;
    logic [REG_W-1:0]               rf_reg;
    logic [DATA_W-1:0]              rf_data;
    logic [TAG_W-1:0]               rf_tag;
    logic                           dc_req;
    logic [3:0]                     dc_mask;
    logic [ADDR_W-1:0]              dc_addr;
    logic [DATA_W-1:0]              dc_data;
    logic                           dc_ack;
    logic                           store_stall;
    logic                           flush;
    logic                           pc_redirect;
    logic [ADDR_W-1:0]              npc;
    logic                           brp_update;
    logic [BADDR_W-1:0]             brp_addr;
    logic                           brp_taken;
    logic [TAG_W:0]                 count;

    modport master (
        output alloc_valid, alloc_op, alloc_reg, alloc_npc, alloc_baddr,
               chk_tag1, chk_tag2, cdb_valid, cdb_tag, cdb_value, cdb_addr,
               bra_valid, bra_tag, bra_taken, bra_mispred, dc_ack,
        input  alloc_ready, alloc_tag, chk_val1, chk_val2, chk_rdy1, chk_rdy2,
               rf_we, rf_reg, rf_data, rf_tag, dc_req, dc_mask, dc_addr, dc_data,
               store_stall, flush, pc_redirect, npc, brp_update, brp_addr,
               brp_taken, count
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_reg, alloc_npc, alloc_baddr,
               chk_tag1, chk_tag2, cdb_valid, cdb_tag, cdb_value, cdb_addr,
               bra_valid, bra_tag, bra_taken, bra_mispred, dc_ack,
        output alloc_ready, alloc_tag, chk_val1, chk_val2, chk_rdy1, chk_rdy2,
               rf_we, rf_reg, rf_data, rf_tag, dc_req, dc_mask, dc_addr, dc_data,
               store_stall, flush, pc_redirect, npc, brp_update, brp_addr,
               brp_taken, count
    );
endinterface

// File: rtl/rob_multi.sv
// In-order-retire reorder buffer with multi-port CDB completion, store handshake
// and precise mispredict flush. Define ROB_BYPASS_EN to forward CDB onto the check ports.
module rob_multi #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 3,
    parameter int CDB_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int ADDR_W    = 32,
    parameter int BADDR_W   = 10
) (
    input  logic clk,
    input  logic rst,
    rob_if.slave rob
);
    localparam logic [2:0] OP_NORM = 3'd0, OP_BR = 3'd1, OP_SB = 3'd2, OP_SH = 3'd3, OP_SW = 3'd4;
    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0]   r_head, r_tail;
    logic [TAG_W:0]     r_count;
    logic [DEPTH-1:0]   r_busy, r_done, r_taken, r_mispred;
    logic [2:0]         r_op    [DEPTH];
    logic [REG_W-1:0]   r_reg   [DEPTH];
    logic [ADDR_W-1:0]  r_npc   [DEPTH];
    logic [BADDR_W-1:0] r_baddr [DEPTH];
    logic [DATA_W-1:0]  r_val   [DEPTH];
    logic [ADDR_W-1:0]  r_addr  [DEPTH];
    logic               r_rf_we;
    logic [REG_W-1:0]   r_rf_reg;
    logic [DATA_W-1:0]  r_rf_data;
    logic [TAG_W-1:0]   r_rf_tag;

    logic w_head_rdy, w_is_br, w_is_store, w_retire, w_flush, w_alloc_rdy, w_alloc;

    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_SB:   return 4'b0001 << a;
            OP_SH:   return (a == 2'b00) ? 4'b0011 : (a == 2'b10) ? 4'b1100 : 4'b0000;
            OP_SW:   return (a == 2'b00) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] op, input logic [1:0] a,
                                                   input logic [DATA_W-1:0] d);
        case (op)
            OP_SB:   return d << {a, 3'b000};
            OP_SH:   return (a == 2'b10) ? (d << 16) : d;
            default: return d;
        endcase
    endfunction

    assign w_head_rdy  = (r_count != '0) && r_done[r_head];
    assign w_is_br     = (r_op[r_head] == OP_BR);
    assign w_is_store  = (r_op[r_head] == OP_SB) || (r_op[r_head] == OP_SH) || (r_op[r_head] == OP_SW);
    assign w_retire    = w_head_rdy && (!w_is_store || rob.dc_ack);
    assign w_flush     = w_head_rdy && w_is_br && r_mispred[r_head];
    assign w_alloc_rdy = !rst && !w_flush && ((r_count != FULL) || w_retire);
    assign w_alloc     = rob.alloc_valid && w_alloc_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_busy    <= '0;
            r_done    <= '0;
            r_rf_we   <= 1'b0;
            r_rf_reg  <= '0;
            r_rf_data <= '0;
            r_rf_tag  <= '0;
        end else begin
            r_rf_we <= w_retire && !w_is_br && !w_is_store;
            if (w_retire && !w_is_br && !w_is_store) begin
                r_rf_reg  <= r_reg[r_head];
                r_rf_data <= r_val[r_head];
                r_rf_tag  <= r_head;
            end
            // descending scan so the lowest port's write lands last and wins
            if (!w_flush) begin
                for (int p = CDB_PORTS-1; p >= 0; p--) begin
                    if (rob.cdb_valid[p] && r_busy[rob.cdb_tag[p*TAG_W +: TAG_W]]
                        && !r_done[rob.cdb_tag[p*TAG_W +: TAG_W]]) begin
                        r_done[rob.cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                        r_val[rob.cdb_tag[p*TAG_W +: TAG_W]]  <= rob.cdb_value[p*DATA_W +: DATA_W];
                        if (r_op[rob.cdb_tag[p*TAG_W +: TAG_W]] inside {OP_SB, OP_SH, OP_SW})
                            r_addr[rob.cdb_tag[p*TAG_W +: TAG_W]] <= rob.cdb_addr[p*ADDR_W +: ADDR_W];
                    end
                end
                if (rob.bra_valid && r_busy[rob.bra_tag] && !r_done[rob.bra_tag]) begin
                    r_done[rob.bra_tag]    <= 1'b1;
                    r_taken[rob.bra_tag]   <= rob.bra_taken;
                    r_mispred[rob.bra_tag] <= rob.bra_mispred;
                end
            end
            if (w_retire) begin
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
            end
            if (w_flush) begin
                r_busy  <= '0;
                r_done  <= '0;
                r_tail  <= r_head + 1'b1;
                r_count <= '0;
            end else begin
                case ({w_alloc, w_retire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            // a same-cycle alloc into the slot just retired must win over the clear above
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_op[r_tail]    <= rob.alloc_op;
                r_reg[r_tail]   <= rob.alloc_reg;
                r_npc[r_tail]   <= rob.alloc_npc;
                r_baddr[r_tail] <= rob.alloc_baddr;
                r_tail          <= r_tail + 1'b1;
            end
        end
    end

    always_comb begin
        rob.alloc_ready = w_alloc_rdy;
        rob.alloc_tag   = r_tail;
        rob.count       = r_count;
        rob.rf_we       = r_rf_we;
        rob.rf_reg      = r_rf_reg;
        rob.rf_data     = r_rf_data;
        rob.rf_tag      = r_rf_tag;
        rob.dc_req      = w_head_rdy && w_is_store;
        rob.dc_mask     = 4'b0000;
        rob.dc_addr     = '0;
        rob.dc_data     = '0;
        rob.store_stall = rob.dc_req && !rob.dc_ack;
        rob.brp_update  = w_head_rdy && w_is_br;
        rob.brp_addr    = '0;
        rob.brp_taken   = 1'b0;
        rob.flush       = w_flush;
        rob.pc_redirect = w_flush;
        rob.npc         = '0;
        if (rob.dc_req) begin
            rob.dc_mask = lane_mask(r_op[r_head], r_addr[r_head][1:0]);
            rob.dc_addr = {r_addr[r_head][ADDR_W-1:2], 2'b00};
            rob.dc_data = lane_data(r_op[r_head], r_addr[r_head][1:0], r_val[r_head]);
        end
        if (rob.brp_update) begin
            rob.brp_addr  = r_baddr[r_head];
            rob.brp_taken = r_taken[r_head];
        end
        if (w_flush)
            rob.npc = r_npc[r_head];
    end

    logic [TAG_W-1:0]  w_ct [2];
    logic              w_cr [2];
    logic [DATA_W-1:0] w_cv [2];

    assign w_ct[0]      = rob.chk_tag1;
    assign w_ct[1]      = rob.chk_tag2;
    assign rob.chk_rdy1 = w_cr[0];
    assign rob.chk_val1 = w_cv[0];
    assign rob.chk_rdy2 = w_cr[1];
    assign rob.chk_val2 = w_cv[1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_cr[k] = r_done[w_ct[k]];
            w_cv[k] = r_done[w_ct[k]] ? r_val[w_ct[k]] : '0;
`ifdef ROB_BYPASS_EN
            if (!r_done[w_ct[k]] && r_busy[w_ct[k]]) begin
                for (int p = CDB_PORTS-1; p >= 0; p--) begin
                    if (rob.cdb_valid[p] && rob.cdb_tag[p*TAG_W +: TAG_W] == w_ct[k]) begin
                        w_cr[k] = 1'b1;
                        w_cv[k] = rob.cdb_value[p*DATA_W +: DATA_W];
                    end
                end
            end
`else
            w_cr[k] = w_cr[k];
`endif
        end
    end
endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: stimulus pushes expected retire/store/branch
// events into queues; a negedge monitor pops and compares them.
module tb_rob_multi;
    localparam int TAG_W = 3, CDB_PORTS = 2, DATA_W = 32, REG_W = 5, ADDR_W = 32, BADDR_W = 10;
`ifdef ROB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk, rst;
    int   n_vec, n_fail;

    rob_if #(.TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS), .DATA_W(DATA_W), .REG_W(REG_W),
             .ADDR_W(ADDR_W), .BADDR_W(BADDR_W)) rif ();

    rob_multi #(.DEPTH(8), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS), .DATA_W(DATA_W),
                .REG_W(REG_W), .ADDR_W(ADDR_W), .BADDR_W(BADDR_W))
        dut (.clk(clk), .rst(rst), .rob(rif.slave));

    typedef struct packed { logic [4:0] rg; logic [31:0] data; logic [2:0] tag; } rf_t;
    typedef struct packed { logic [3:0] mask; logic [31:0] addr; logic [31:0] data; } st_t;
    typedef struct packed { logic [9:0] baddr; logic taken; logic fl; logic [31:0] npc; } br_t;
    rf_t q_rf[$];
    st_t q_st[$];
    br_t q_br[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.alloc_valid = 0; rif.alloc_op = 0; rif.alloc_reg = 0; rif.alloc_npc = 0; rif.alloc_baddr = 0;
        rif.cdb_valid = 0; rif.cdb_tag = 0; rif.cdb_value = 0; rif.cdb_addr = 0;
        rif.bra_valid = 0; rif.bra_tag = 0; rif.bra_taken = 0; rif.bra_mispred = 0;
        rif.dc_ack = 0;
    endtask

    task automatic set_alloc(input logic [2:0] op, input logic [4:0] rg, input logic [31:0] npc,
                             input logic [9:0] ba);
        rif.alloc_valid = 1; rif.alloc_op = op; rif.alloc_reg = rg; rif.alloc_npc = npc; rif.alloc_baddr = ba;
    endtask

    task automatic set_cdb(input int p, input logic [2:0] tag, input logic [31:0] v, input logic [31:0] a);
        rif.cdb_valid[p] = 1'b1;
        rif.cdb_tag[p*TAG_W +: TAG_W] = tag;
        rif.cdb_value[p*DATA_W +: DATA_W] = v;
        rif.cdb_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_store(input logic [2:0] op, input logic [2:0] tag, input logic [31:0] v,
                            input logic [31:0] a, input st_t exp);
        check("st_alloc_tag", 64'(rif.alloc_tag), 64'(tag));
        set_alloc(op, 0, 0, 0); cyc(); idle();
        set_cdb(0, tag, v, a); q_st.push_back(exp); cyc(); idle();
        rif.dc_ack = 1; cyc(); idle();
        check("st_count", 64'(rif.count), 0);
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (rif.count != 0 && n < 30) begin cyc(); n++; end
        check(nm, 64'(rif.count), 0);
    endtask

    // monitor: compares every output event against the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (rif.rf_we) begin
                if (q_rf.size() == 0) check("rf_unexpected", 1, 0);
                else begin
                    rf_t e;
                    e = q_rf.pop_front();
                    check("rf_reg", 64'(rif.rf_reg), 64'(e.rg));
                    check("rf_data", 64'(rif.rf_data), 64'(e.data));
                    check("rf_tag", 64'(rif.rf_tag), 64'(e.tag));
                end
            end
            if (rif.dc_req && rif.dc_ack) begin
                if (q_st.size() == 0) check("st_unexpected", 1, 0);
                else begin
                    st_t e;
                    e = q_st.pop_front();
                    check("dc_mask", 64'(rif.dc_mask), 64'(e.mask));
                    check("dc_addr", 64'(rif.dc_addr), 64'(e.addr));
                    check("dc_data", 64'(rif.dc_data), 64'(e.data));
                end
            end
            if (rif.brp_update) begin
                if (q_br.size() == 0) check("br_unexpected", 1, 0);
                else begin
                    br_t e;
                    e = q_br.pop_front();
                    check("brp_addr", 64'(rif.brp_addr), 64'(e.baddr));
                    check("brp_taken", 64'(rif.brp_taken), 64'(e.taken));
                    check("flush", 64'(rif.flush), 64'(e.fl));
                    check("pc_redirect", 64'(rif.pc_redirect), 64'(e.fl));
                    check("npc", 64'(rif.npc), 64'(e.npc));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_fail = 0;
        idle(); rif.chk_tag1 = 0; rif.chk_tag2 = 0;
        rst = 1;
        cyc(); cyc();
        check("rst_alloc_ready", 64'(rif.alloc_ready), 0);
        rst = 0; #1;
        check("rst_count", 64'(rif.count), 0);
        check("rst_alloc_ready_after", 64'(rif.alloc_ready), 1);
        check("rst_alloc_tag", 64'(rif.alloc_tag), 0);
        check("rst_outs", {rif.rf_we, rif.dc_req, rif.flush, rif.brp_update, rif.chk_rdy1}, 0);

        // fill to full, then a ninth allocation must be ignored
        for (int i = 0; i < 8; i++) begin set_alloc(0, 5'(i+1), 0, 0); cyc(); end
        idle(); #1;
        check("full_count", 64'(rif.count), 8);
        check("full_ready", 64'(rif.alloc_ready), 0);
        check("full_tail_wrap", 64'(rif.alloc_tag), 0);
        set_alloc(0, 9, 0, 0); #1;
        check("ninth_ready", 64'(rif.alloc_ready), 0);
        cyc(); idle(); #1;
        check("ninth_count", 64'(rif.count), 8);
        check("ninth_tail", 64'(rif.alloc_tag), 0);

        // head done at full: retire and alloc in the same cycle
        set_cdb(0, 0, 32'h100, 0); q_rf.push_back('{5'd1, 32'h100, 3'd0}); cyc(); idle();
        set_alloc(0, 9, 0, 0); #1;
        check("full_retire_ready", 64'(rif.alloc_ready), 1);
        cyc(); idle(); #1;
        check("full_retire_count", 64'(rif.count), 8);
        check("full_retire_tail", 64'(rif.alloc_tag), 1);

        // both CDB ports hit tag 1: lowest port wins
        rif.chk_tag1 = 1;
        set_cdb(0, 1, 32'h11, 0); set_cdb(1, 1, 32'h22, 0); #1;
        check("dual_bypass_rdy", 64'(rif.chk_rdy1), 64'(BYP));
        q_rf.push_back('{5'd2, 32'h11, 3'd1});
        cyc(); idle(); #1;
        check("dual_chk_rdy", 64'(rif.chk_rdy1), 1);
        check("dual_chk_val", 64'(rif.chk_val1), 32'h11);
        for (int t = 2; t < 8; t += 2) begin
            set_cdb(0, 3'(t), 32'h200 + t, 0); set_cdb(1, 3'(t+1), 32'h201 + t, 0);
            q_rf.push_back('{5'(t+1), 32'h200 + t, 3'(t)});
            q_rf.push_back('{5'(t+2), 32'h201 + t, 3'(t+1)});
            cyc(); idle();
        end
        set_cdb(1, 0, 32'h200, 0); q_rf.push_back('{5'd9, 32'h200, 3'd0}); cyc(); idle();
        wait_empty("drain_count");

        // single normal op through CDB port 1
        check("b_alloc_tag", 64'(rif.alloc_tag), 1);
        set_alloc(0, 5, 0, 0); cyc(); idle();
        set_cdb(1, 1, 32'h1234, 0); q_rf.push_back('{5'd5, 32'h1234, 3'd1}); cyc(); idle();
        rif.chk_tag1 = 1; #1;
        check("b_chk_rdy", 64'(rif.chk_rdy1), 1);
        check("b_chk_val", 64'(rif.chk_val1), 32'h1234);
        cyc();
        check("b_count", 64'(rif.count), 0);
        check("b_rf_we", 64'(rif.rf_we), 1);

        // SB held without ack
        check("c_alloc_tag", 64'(rif.alloc_tag), 2);
        set_alloc(2, 0, 0, 0); cyc(); idle();
        set_cdb(0, 2, 32'hAB, 32'h1003); q_st.push_back('{4'b1000, 32'h1000, 32'hAB000000}); cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            check("c_dc_req", 64'(rif.dc_req), 1);
            check("c_stall", 64'(rif.store_stall), 1);
            check("c_head_hold", 64'(rif.count), 1);
            cyc();
        end
        rif.dc_ack = 1; #1;
        check("c_stall_ack", 64'(rif.store_stall), 0);
        cyc(); idle(); #1;
        check("c_req_drop", 64'(rif.dc_req), 0);
        check("c_count", 64'(rif.count), 0);
        do_store(3'd3, 3, 32'h5678, 32'h2002, '{4'b1100, 32'h2000, 32'h56780000});
        do_store(3'd4, 4, 32'hDEADBEEF, 32'h3001, '{4'b0000, 32'h3000, 32'hDEADBEEF});
        do_store(3'd4, 5, 32'hCAFEF00D, 32'h4000, '{4'b1111, 32'h4000, 32'hCAFEF00D});

        // mispredicted branch at tag 6 with three younger entries
        check("d_alloc_tag", 64'(rif.alloc_tag), 6);
        set_alloc(1, 0, 32'h40, 10'h155); cyc();
        for (int i = 0; i < 3; i++) begin set_alloc(0, 5'(10+i), 0, 0); cyc(); end
        idle();
        rif.bra_valid = 1; rif.bra_tag = 6; rif.bra_taken = 1; rif.bra_mispred = 1;
        q_br.push_back('{10'h155, 1'b1, 1'b1, 32'h40});
        cyc(); idle();
        set_alloc(0, 20, 0, 0); set_cdb(0, 7, 32'h77, 0); #1;
        check("d_flush", 64'(rif.flush), 1);
        check("d_flush_blocks_alloc", 64'(rif.alloc_ready), 0);
        cyc(); idle(); #1;
        check("d_count", 64'(rif.count), 0);
        check("d_tail", 64'(rif.alloc_tag), 7);
        set_cdb(0, 0, 32'h99, 0); cyc(); idle(); cyc(); cyc();
        check("d_late_count", 64'(rif.count), 0);
        rif.chk_tag1 = 0; #1;
        check("d_late_chk", 64'(rif.chk_rdy1), 0);

        // correctly predicted branch: predictor update without flush
        set_alloc(1, 0, 32'h80, 10'h3); cyc(); idle();
        rif.bra_valid = 1; rif.bra_tag = 7; rif.bra_taken = 0; rif.bra_mispred = 0;
        q_br.push_back('{10'h3, 1'b0, 1'b0, 32'h0});
        cyc(); idle(); #1;
        check("e_no_flush", 64'(rif.flush), 0);
        check("e_brp_update", 64'(rif.brp_update), 1);
        cyc();
        check("e_count", 64'(rif.count), 0);

        // reset while a store is pending
        set_alloc(2, 0, 0, 0); cyc(); idle();
        set_cdb(0, 0, 32'h1, 32'h10); cyc(); idle();
        check("f_dc_req", 64'(rif.dc_req), 1);
        rst = 1; cyc(); rst = 0; #1;
        check("f_req_drop", 64'(rif.dc_req), 0);
        check("f_count", 64'(rif.count), 0);

        cyc(); cyc();
        check("q_rf_empty", 64'(q_rf.size()), 0);
        check("q_st_empty", 64'(q_st.size()), 0);
        check("q_br_empty", 64'(q_br.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
